// File: rtl/fft_stage_ctrl.sv
// Radix-2 DIT FFT sequencer: one butterfly issue per cycle, pipeline drain between stages.
// Optional FFT_CTRL_HOLD_EN adds a hold input that stalls issue during ISSUE.
module fft_stage_ctrl #(
    parameter int ADDR_WIDTH = 3,
    parameter int BF_LAT     = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
`ifdef FFT_CTRL_HOLD_EN
    input  logic                    hold,
`endif
    output logic                    busy,
    output logic                    done,
    output logic [ADDR_WIDTH-1:0]   rd_addr_a,
    output logic [ADDR_WIDTH-1:0]   rd_addr_b,
    output logic [ADDR_WIDTH-2:0]   tw_addr,
    output logic [2*ADDR_WIDTH-1:0] m_in,
    output logic                    bf_valid,
    output logic                    wr_en,
    output logic                    rd_bank,
    output logic [ADDR_WIDTH-1:0]   stage
);
    localparam int AW   = ADDR_WIDTH;
    localparam int HALF = (1 << AW) / 2;
    localparam int CW   = $clog2(BF_LAT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t          state, state_nxt;
    logic [AW-1:0]   k, k_nxt, stage_nxt;
    logic            bank_nxt, load;
    logic [CW-1:0]   dcnt, dcnt_nxt;
    logic [BF_LAT-1:0] vld_pipe;
    logic            stall;
    logic [AW-1:0]   h, pos, grp, a_nxt, b_nxt, tw_full;

`ifdef FFT_CTRL_HOLD_EN
    assign stall = hold;
`else
    assign stall = 1'b0;
`endif

    assign bf_valid = (state == ISSUE) && !stall;
    assign busy     = (state == ISSUE) || (state == DRAIN);
    assign done     = (state == DONE);
    assign m_in     = {rd_addr_a, rd_addr_b};
    assign wr_en    = vld_pipe[BF_LAT-1];

    // Address generation for the butterfly that will be on the outputs next cycle
    always_comb begin
        h       = AW'(1) << stage_nxt;
        pos     = k_nxt & (h - AW'(1));
        grp     = k_nxt >> stage_nxt;
        a_nxt   = ((grp << stage_nxt) << 1) | pos;
        b_nxt   = a_nxt | h;
        tw_full = pos << (AW'(AW - 1) - stage_nxt);
    end

    always_comb begin
        state_nxt = state;
        k_nxt     = k;
        stage_nxt = stage;
        bank_nxt  = rd_bank;
        dcnt_nxt  = dcnt;
        load      = 1'b0;
        case (state)
            IDLE: if (start) begin
                state_nxt = ISSUE;
                k_nxt     = '0;
                stage_nxt = '0;
                bank_nxt  = 1'b0;
                load      = 1'b1;
            end
            ISSUE: if (!stall) begin
                if (k == AW'(HALF - 1)) begin
                    state_nxt = DRAIN;
                    k_nxt     = '0;
                    dcnt_nxt  = '0;
                end else begin
                    k_nxt = k + AW'(1);
                    load  = 1'b1;
                end
            end
            DRAIN: if (dcnt == CW'(BF_LAT - 1)) begin
                if (stage == AW'(AW - 1)) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = ISSUE;
                    stage_nxt = stage + AW'(1);
                    bank_nxt  = ~rd_bank;
                    load      = 1'b1;
                end
            end else begin
                dcnt_nxt = dcnt + CW'(1);
            end
            DONE: begin
                state_nxt = IDLE;
                stage_nxt = '0;
                bank_nxt  = 1'b0;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            k         <= '0;
            stage     <= '0;
            rd_bank   <= 1'b0;
            dcnt      <= '0;
            rd_addr_a <= '0;
            rd_addr_b <= '0;
            tw_addr   <= '0;
            vld_pipe  <= '0;
        end else begin
            state    <= state_nxt;
            k        <= k_nxt;
            stage    <= stage_nxt;
            rd_bank  <= bank_nxt;
            dcnt     <= dcnt_nxt;
            vld_pipe <= (vld_pipe << 1) | BF_LAT'(bf_valid);
            // addresses hold their last value through DRAIN and stalls
            if (load) begin
                rd_addr_a <= a_nxt;
                rd_addr_b <= b_nxt;
                tw_addr   <= tw_full[AW-2:0];
            end
        end
    end
endmodule

// File: tb/tb_fft_stage_ctrl.sv
// Bench for fft_stage_ctrl: scoreboarded issue/write sequences plus per-cycle timing checks.
module tb_fft_stage_ctrl;
    localparam int AW = 3, LAT = 6, N = 8, HALF = 4, L = 3;
    localparam int P = HALF + LAT, TOT = L * P + 1;

    logic clk = 0, rst = 1, start = 0;
`ifdef FFT_CTRL_HOLD_EN
    logic hold = 1'b0;
`endif
    logic busy, done, bf_valid, wr_en, rd_bank;
    logic [AW-1:0] rd_addr_a, rd_addr_b, stage;
    logic [AW-2:0] tw_addr;
    logic [2*AW-1:0] m_in;

    fft_stage_ctrl #(.ADDR_WIDTH(AW), .BF_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .start(start),
`ifdef FFT_CTRL_HOLD_EN
        .hold(hold),
`endif
        .busy(busy), .done(done), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .tw_addr(tw_addr), .m_in(m_in), .bf_valid(bf_valid), .wr_en(wr_en),
        .rd_bank(rd_bank), .stage(stage)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    logic [11:0] issue_q[$];
    logic [5:0]  wr_q[$];
    logic [5:0]  mhist[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected butterflies enumerated group-by-group, independent of the counter form
    task automatic push_run();
        int h;
        for (int s = 0; s < L; s++) begin
            h = 1 << s;
            for (int g = 0; g < N; g += 2 * h)
                for (int j = 0; j < h; j++) begin
                    issue_q.push_back({1'(s % 2), 3'(s), 2'(j * (N / (2 * h))), 3'(g + j), 3'(g + j + h)});
                    wr_q.push_back({3'(g + j), 3'(g + j + h)});
                end
        end
    endtask

    function automatic logic exp_v(int n);
        int r;
        r = (n - 1) % P;
        return (n <= L * P) && (r < HALF);
    endfunction

    function automatic logic exp_w(int n);
        int r;
        r = (n - 1) % P;
        return (n <= L * P) && (r >= LAT) && (r < LAT + HALF);
    endfunction

    always @(negedge clk) begin
        mhist.push_front(m_in);
        if (mhist.size() > LAT + 1) void'(mhist.pop_back());
        if (!rst && bf_valid) begin
            if (issue_q.size() == 0) check("issue_unexpected", 1, 0);
            else check("issue", {rd_bank, stage, tw_addr, rd_addr_a, rd_addr_b}, issue_q.pop_front());
        end
        if (!rst && wr_en) begin
            if (wr_q.size() == 0 || mhist.size() <= LAT) check("wr_unexpected", 1, 0);
            else check("wr_m_out", mhist[LAT], wr_q.pop_front());
        end
    end

    // One FFT; optional start pulses during cycles p1/p2, optional reset at cycle abort_at
    task automatic run(input int p1, input int p2, input int abort_at);
        push_run();
        start = 1;
        @(posedge clk);
        #1 start = 0;
        for (int n = 1; n <= TOT; n++) begin
            @(negedge clk);
            if (n == abort_at) begin
                #1 rst = 1;
                #1 check("abort_outs", {busy, done, rd_addr_a, rd_addr_b, tw_addr, m_in,
                                        bf_valid, wr_en, rd_bank, stage}, 0);
                issue_q.delete();
                wr_q.delete();
                return;
            end
            check($sformatf("bf_valid@%0d", n), bf_valid, exp_v(n));
            check($sformatf("wr_en@%0d", n), wr_en, exp_w(n));
            check($sformatf("done@%0d", n), done, n == TOT);
            check($sformatf("busy@%0d", n), busy, n < TOT);
            start = (n == p1 || n == p2);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_outs", {busy, done, rd_addr_a, rd_addr_b, tw_addr, m_in,
                             bf_valid, wr_en, rd_bank, stage}, 0);
        rst = 0;
        @(negedge clk);
        check("idle_busy", busy, 0);

        run(5, 31, -1);
        @(negedge clk);
        start = 0;
        check("ignored_start_busy", busy, 0);
        check("ignored_start_valid", bf_valid, 0);
        run(-1, -1, -1);

        @(negedge clk);
        run(-1, -1, 13);
        repeat (2) @(negedge clk);
        rst = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("post_abort_wr_en", wr_en, 0);
            check("post_abort_valid", bf_valid, 0);
        end
        run(-1, -1, -1);

        repeat (2) @(negedge clk);
        check("issue_q_left", issue_q.size(), 0);
        check("wr_q_left", wr_q.size(), 0);
        check("final_stage", stage, 0);
        check("final_bank", rd_bank, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
